// File: rtl/jtag_interface_dr.sv
// jtag_interface_dr: data-register bank on the TAP tck domain.
// Decodes the active instruction. Runs the IDCODE (32b), STATUS (8b) and ACCESS (64b) data registers.
// Converts ACCESS updates into a valid/ready request and buffers one response for later scan-out.
// Ports:
//   clk, rst            tck and synchronous active-high reset
//   instructions        active instruction from the TAP
//   capture/shift/update_dr_state  TAP DR state flags
//   tdi, so             serial in / serial out (so = shreg[0])
//   bypass_sel          1 when the instruction selects none of the bank's registers
//   req_val/req_data/req_rdy       outgoing 64-bit request
//   resp_val/resp_data             incoming 64-bit response strobe
module jtag_interface_dr #(
    parameter int unsigned           INSTR_W    = 8,
    parameter logic [31:0]           IDCODE_VAL = 32'h0000_0001,
    parameter logic [INSTR_W-1:0]    OP_IDCODE  = INSTR_W'(8'h01),
    parameter logic [INSTR_W-1:0]    OP_ACCESS  = INSTR_W'(8'h10),
    parameter logic [INSTR_W-1:0]    OP_STATUS  = INSTR_W'(8'h11)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [INSTR_W-1:0] instructions,
    input  logic               capture_dr_state,
    input  logic               shift_dr_state,
    input  logic               update_dr_state,
    input  logic               tdi,
    output logic               so,
    output logic               bypass_sel,
    output logic               req_val,
    output logic [63:0]        req_data,
    input  logic               req_rdy,
    input  logic               resp_val,
    input  logic [63:0]        resp_data
);

    localparam int unsigned DATA_W = 64;
    localparam int unsigned ID_W   = 32;
    localparam int unsigned ST_W   = 8;

    logic [DATA_W-1:0] shreg;
    logic [DATA_W-1:0] shreg_nxt;
    logic [DATA_W-1:0] resp_buf;
    logic              resp_full;
    logic              ovf;

    logic              sel_id;
    logic              sel_acc;
    logic              sel_st;
    logic              update_acc;
    logic              slot_free;
    logic              req_load;
    logic              ovf_event;
    logic [ST_W-1:0]   status_word;

    // Instruction decode
    assign sel_id     = (instructions == OP_IDCODE);
    assign sel_acc    = (instructions == OP_ACCESS);
    assign sel_st     = (instructions == OP_STATUS);
    assign bypass_sel = ~(sel_id | sel_acc | sel_st);

    // The TAP re-times so on the negedge, so it is taken straight from the register
    assign so = shreg[0];

    // Request slot is usable if empty or being accepted in this same cycle
    assign update_acc = update_dr_state & sel_acc;
    assign slot_free  = ~req_val | req_rdy;
    assign req_load   = update_acc & slot_free;

    // Dropped update or response overwrite both count as overflow
    assign ovf_event  = (update_acc & ~slot_free) | (resp_val & resp_full);

    assign status_word = {5'b0, ovf, resp_full, req_val};

    // Shift register next value: capture has priority over shift
    always_comb begin
        shreg_nxt = shreg;
        if (capture_dr_state) begin
            if (sel_id) begin
                shreg_nxt = {32'b0, IDCODE_VAL};
            end else if (sel_acc) begin
                shreg_nxt = resp_buf;
            end else if (sel_st) begin
                shreg_nxt = {56'b0, status_word};
            end
        end else if (shift_dr_state) begin
            // tdi enters at the MSB of the active length; upper bits stay zero
            if (sel_id) begin
                shreg_nxt = {(DATA_W-ID_W)'(0), tdi, shreg[ID_W-1:1]};
            end else if (sel_acc) begin
                shreg_nxt = {tdi, shreg[DATA_W-1:1]};
            end else if (sel_st) begin
                shreg_nxt = {(DATA_W-ST_W)'(0), tdi, shreg[ST_W-1:1]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg <= '0;
        end else begin
            shreg <= shreg_nxt;
        end
    end

    // Request slot: load on accepted update, clear on handshake otherwise
    always_ff @(posedge clk) begin
        if (rst) begin
            req_val  <= 1'b0;
            req_data <= '0;
        end else if (req_load) begin
            req_val  <= 1'b1;
            req_data <= shreg;
        end else if (req_rdy) begin
            req_val  <= 1'b0;
        end
    end

    // Response buffer: a new response wins over the clear from an ACCESS capture
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_buf  <= '0;
            resp_full <= 1'b0;
        end else if (resp_val) begin
            resp_buf  <= resp_data;
            resp_full <= 1'b1;
        end else if (capture_dr_state & sel_acc) begin
            resp_full <= 1'b0;
        end
    end

    // Sticky overflow; a STATUS capture clears it unless a new event lands the same cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (capture_dr_state & sel_st) begin
            ovf <= ovf_event;
        end else if (ovf_event) begin
            ovf <= 1'b1;
        end
    end

endmodule

// File: doc/jtag_interface_dr.md
# jtag_interface_dr

Data-register bank on the TAP's `tck` domain, directly downstream of the JTAG TAP controller. Decodes the current instruction and uses the TAP's capture/shift/update DR state flags to run the IDCODE, STATUS and ACCESS data registers. Returns the serial output and bypass select to the TAP. Converts each ACCESS update into a 64-bit valid/ready request and buffers one 64-bit response for later scan-out.

## Interface
Parameters:
- `INSTR_W`, 8, instruction width; must equal the TAP instruction width.
- `IDCODE_VAL`, 32'h0000_0001, value captured by IDCODE; bit 0 must be 1.
- `OP_IDCODE`, 8'h01, IDCODE opcode.
- `OP_ACCESS`, 8'h10, ACCESS opcode (64-bit DR).
- `OP_STATUS`, 8'h11, STATUS opcode (8-bit DR).

Ports:
- `clk`  in  1  `tck`; all state updates on the posedge.
- `rst`  in  1  synchronous, active-high.
- `instructions`  in  INSTR_W  active instruction from the TAP.
- `capture_dr_state`  in  1  TAP is in Capture-DR.
- `shift_dr_state`  in  1  TAP is in Shift-DR.
- `update_dr_state`  in  1  TAP is in Update-DR.
- `tdi`  in  1  serial data in.
- `so`  out  1  serial out to the TAP; equals `shreg[0]`.
- `bypass_sel`  out  1  combinational; 1 when the instruction is not IDCODE, ACCESS or STATUS.
- `req_val`  out  1  request valid.
- `req_data`  out  64  request payload.
- `req_rdy`  in  1  consumer accepts the request.
- `resp_val`  in  1  one-cycle response strobe.
- `resp_data`  in  64  response payload.

## Operation
- **Decode:** `sel_id`, `sel_acc` and `sel_st` are equality compares on `instructions`. An unknown opcode asserts `bypass_sel`; the bank then ignores capture, shift and update.
- **Shift register:** `shreg[63:0]`.
  - Capture:
    - IDCODE loads `{32'b0, IDCODE_VAL}`.
    - ACCESS loads `resp_buf`.
    - STATUS loads `{56'b0, 5'b0, ovf, resp_full, req_val}`.
  - Shift: right shift, with `tdi` inserted at the register MSB position, which depends on length.
    - ACCESS: bit 63.
    - IDCODE: bit 31.
    - STATUS: bit 7.
    - Bits above the active length are held at 0.
  - Capture and shift are mutually exclusive by TAP construction. If both are asserted, capture wins.
- **ACCESS update:** on `update_dr_state & sel_acc`:
  - If the request slot is free, or is being accepted this cycle (`req_val & req_rdy`): load `req_data <= shreg` and set `req_val <= 1`.
  - Otherwise: drop the update, set `ovf <= 1`, and leave `req_data` unchanged.
- **Request handshake:**
  - `req_val` stays high until a cycle with `req_rdy = 1`, then clears unless reloaded in that same cycle.
  - `req_data` is stable while `req_val` is high.
- **Response:**
  - `resp_val` loads `resp_buf <= resp_data` and sets `resp_full <= 1`.
  - A new `resp_val` while `resp_full` is set overwrites the buffer and sets `ovf`.
  - Capture under ACCESS clears `resp_full`. If `resp_val` arrives in the same cycle, the buffer and `resp_full` take the new response and the capture loads the old buffer.
- **Overflow flag:** `ovf` is sticky and cleared by Capture-DR under STATUS. The captured value is the pre-clear value. A new overflow event in the same cycle leaves `ovf = 1`.
- **STATUS and IDCODE updates** have no side effects.

## Timing
- Reset values: `shreg = 0`, `so = 0`, `req_val = 0`, `req_data = 0`, `resp_buf = 0`, `resp_full = 0`, `ovf = 0`.
- `rst` overrides every event in the same cycle, including a pending handshake. `req_val` drops with no acceptance implied.
- `so` is combinational from `shreg[0]`. The TAP re-times it on the negedge, so the first bit out during Shift-DR is bit 0 of the captured value.
- **Capture to bits:** the Capture-DR posedge loads `shreg`; each Shift-DR posedge emits one bit. An N-bit register needs N shift cycles.
- **Update to request:** `req_val` rises on the posedge ending Update-DR, one-cycle latency. Accepting a request needs at least one cycle with `req_rdy` high after `req_val` rises.
- **Back-to-back:** minimum TAP spacing between ACCESS updates is 4+64 cycles. With `req_rdy` tied high there are no drops.

## Test plan
- **Reset and IDCODE:**
  - Stimulus: assert `rst` for 2 cycles, then instruction 8'h01 with capture followed by 32 shifts.
  - Required: `so` emits 32'h0000_0001 LSB first; `bypass_sel = 0`; all reset values are checked before the capture.
- **ACCESS write:**
  - Stimulus: shift in 64'hDEAD_BEEF_0123_4567, then update, with `req_rdy = 0` for 3 cycles and then 1.
  - Required: `req_val` rises one cycle after update, holds the data for 4 cycles, and clears after acceptance.
- **Overflow:**
  - Stimulus: two ACCESS updates with `req_rdy = 0` throughout; then capture STATUS.
  - Required: `req_data` keeps the first payload; STATUS shifts out 8'h05; a second STATUS capture reads 8'h01.
- **Response readback:**
  - Stimulus: `resp_val` with 64'h0123_4567_89AB_CDEF; capture ACCESS and shift 64 bits.
  - Required: `so` streams the value LSB first; STATUS afterwards reads `resp_full = 0`.
- **Simultaneous events:**
  - Stimulus: `resp_val` in the same cycle as an ACCESS capture; update in the same cycle as `req_rdy` with `req_val = 1`.
  - Required: the capture gets the old buffer and `resp_full = 1` afterwards; the new request loads with no overflow.
- **Bypass and mid-operation reset:**
  - Stimulus: instruction 8'hFF; separately, `rst` asserted mid-shift under ACCESS.
  - Required: `bypass_sel = 1` and `shreg` is untouched by the shifts; after the reset all state is 0 and `so = 0`.
